button_event_queue: RTL and testbench



---
 rtl/button_event_queue.sv | 101 ++++++++++
 tb/tb_button_event_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Button event queue: round-robin arbitration across per-button press channels,
// encoding each accepted press as an 8-bit key code and buffering the codes in a
// small FIFO that feeds a single valid/ready byte stream.
module button_event_queue #(
  parameter int         BUTTONS   = 4,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] CODE_BASE = 8'h80
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BUTTONS-1:0] button_valid,
  output logic [BUTTONS-1:0] button_ready,
  output logic               key_valid,
  input  logic               key_ready,
  output logic [7:0]         key_code
);

  localparam int PTR_W = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [PTR_W-1:0] pointer;
  logic [PTR_W-1:0] winner;
  logic             grant;
  logic [7:0]       push_code;
  logic             pop;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    head;
  logic [AW-1:0]    head_next;
  logic [AW-1:0]    tail;
  logic [7:0]       head_code_next;
  logic [7:0]       mem [DEPTH];

  assign key_valid = (count != '0);
  assign pop       = key_valid & key_ready;

  // Round-robin search starting just after the last winner; only grants while the FIFO has room.
  always_comb begin
    int idx;
    idx          = 0;
    grant        = 1'b0;
    winner       = '0;
    button_ready = '0;
    if (!reset && (count < CW'(DEPTH))) begin
      for (int k = 1; k <= BUTTONS; k++) begin
        idx = (int'(pointer) + k) % BUTTONS;
        if (!grant && button_valid[PTR_W'(idx)]) begin
          grant  = 1'b1;
          winner = PTR_W'(idx);
        end
      end
      if (grant) begin
        button_ready[winner] = 1'b1;
      end
    end
  end

  assign push_code = CODE_BASE + 8'(winner);

  // Next occupancy, head position and the code that will sit at the head after this edge.
  always_comb begin
    count_next = count;
    case ({grant, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    head_next      = pop ? head + AW'(1) : head;
    head_code_next = (grant && (head_next == tail)) ? push_code : mem[head_next];
  end

  // Pointer, FIFO indices, occupancy and the registered head code; key_code holds when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer  <= PTR_W'(BUTTONS - 1);
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      key_code <= 8'h00;
    end else begin
      count <= count_next;
      head  <= head_next;
      if (grant) begin
        tail    <= tail + AW'(1);
        pointer <= winner;
      end
      if (count_next != '0) begin
        key_code <= head_code_next;
      end
    end
  end

  // Code storage; writes only happen on a grant, which is blocked during reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem[tail] <= push_code;
    end
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Testbench for button_event_queue: directed vector table plus a randomized
// consumer run with a scoreboard checking order, loss and duplication.
module tb_button_event_queue;

  logic       clk;
  logic       reset;
  logic [3:0] button_valid;
  logic [3:0] button_ready;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;

  int vectors;
  int miscompares;

  typedef struct {
    logic       rst;
    logic [3:0] bv;
    logic       kr;
    logic [3:0] br;
    logic       kv;
    logic [7:0] kc;
  } vec_t;

  vec_t vecs[$];

  button_event_queue #(
    .BUTTONS  (4),
    .DEPTH    (4),
    .CODE_BASE(8'h80)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_valid(button_valid),
    .button_ready(button_ready),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic rst, input logic [3:0] bv, input logic kr,
                        input logic [3:0] br, input logic kv, input logic [7:0] kc);
    vec_t v;
    v.rst = rst; v.bv = bv; v.kr = kr; v.br = br; v.kv = kv; v.kc = kc;
    vecs.push_back(v);
  endtask

  // Drive inputs just after the falling edge and let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic [3:0] bv, input logic kr);
    @(negedge clk);
    reset        = rst;
    button_valid = bv;
    key_ready    = kr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    int   remaining[4];
    logic [3:0] cool;
    logic [7:0] sb[$];
    int   received;
    int   cycles;

    vectors     = 0;
    miscompares = 0;
    reset        = 1'b1;
    button_valid = 4'b1111;
    key_ready    = 1'b0;

    // Reset state: no grants while reset is high, empty queue, zero code.
    @(negedge clk);
    #1;
    checkOutput("reset br", 8'(button_ready), 8'h00);
    @(negedge clk);
    #1;
    checkOutput("reset kv", 8'(key_valid), 8'h00);
    checkOutput("reset kc", key_code, 8'h00);

    // Single press of button 2, one-cycle latency, drain.
    addVec(0, 4'b0100, 0, 4'b0100, 0, 8'h00);
    addVec(0, 4'b0000, 0, 4'b0000, 1, 8'h82);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h82);
    addVec(0, 4'b0000, 0, 4'b0000, 0, 8'h82);
    // Reset to restore pointer, then all four buttons dropped on accept.
    addVec(1, 4'b0000, 0, 4'b0000, 0, 8'h82);
    addVec(0, 4'b1111, 1, 4'b0001, 0, 8'h00);
    addVec(0, 4'b1110, 1, 4'b0010, 1, 8'h80);
    addVec(0, 4'b1100, 1, 4'b0100, 1, 8'h81);
    addVec(0, 4'b1000, 1, 4'b1000, 1, 8'h82);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h83);
    addVec(0, 4'b0000, 0, 4'b0000, 0, 8'h83);
    // Buttons 1 and 3 pressing continuously alternate.
    addVec(0, 4'b1010, 1, 4'b0010, 0, 8'h83);
    addVec(0, 4'b1010, 1, 4'b1000, 1, 8'h81);
    addVec(0, 4'b1010, 1, 4'b0010, 1, 8'h83);
    addVec(0, 4'b1010, 1, 4'b1000, 1, 8'h81);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h83);
    addVec(0, 4'b0000, 0, 4'b0000, 0, 8'h83);
    // Fill to full with the consumer stalled, then drain in order.
    addVec(0, 4'b1111, 0, 4'b0001, 0, 8'h83);
    addVec(0, 4'b1111, 0, 4'b0010, 1, 8'h80);
    addVec(0, 4'b1111, 0, 4'b0100, 1, 8'h80);
    addVec(0, 4'b1111, 0, 4'b1000, 1, 8'h80);
    addVec(0, 4'b1111, 0, 4'b0000, 1, 8'h80);
    addVec(0, 4'b1111, 1, 4'b0000, 1, 8'h80);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 8'h81);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h82);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h83);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h80);
    addVec(0, 4'b0000, 0, 4'b0000, 0, 8'h80);
    // Simultaneous push and pop at count 1.
    addVec(0, 4'b0010, 0, 4'b0010, 0, 8'h80);
    addVec(0, 4'b0001, 1, 4'b0001, 1, 8'h81);
    addVec(0, 4'b0000, 0, 4'b0000, 1, 8'h80);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h80);
    // Three codes queued, reset mid-operation, button 2 still pending.
    addVec(0, 4'b0100, 0, 4'b0100, 0, 8'h80);
    addVec(0, 4'b0010, 0, 4'b0010, 1, 8'h82);
    addVec(0, 4'b1000, 0, 4'b1000, 1, 8'h82);
    addVec(1, 4'b0100, 0, 4'b0000, 1, 8'h82);
    addVec(0, 4'b0100, 0, 4'b0100, 0, 8'h00);
    addVec(0, 4'b0000, 0, 4'b0000, 1, 8'h82);
    addVec(0, 4'b0000, 1, 4'b0000, 1, 8'h82);
    addVec(0, 4'b0000, 0, 4'b0000, 0, 8'h82);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].bv, vecs[i].kr);
      checkOutput($sformatf("v%0d br", i), 8'(button_ready), 8'(vecs[i].br));
      checkOutput($sformatf("v%0d kv", i), 8'(key_valid), 8'(vecs[i].kv));
      checkOutput($sformatf("v%0d kc", i), key_code, vecs[i].kc);
    end

    // Randomized consumer stalls: every button presses three times, nothing lost or duplicated.
    for (int i = 0; i < 4; i++) remaining[i] = 3;
    cool     = '0;
    received = 0;
    cycles   = 0;
    while (received < 12 && cycles < 400) begin
      logic [3:0] bv;
      for (int i = 0; i < 4; i++) bv[i] = (remaining[i] > 0) && !cool[i];
      applyStimulus(1'b0, bv, 1'($urandom_range(0, 1)));
      checkOutput("stress kv", 8'(key_valid), 8'(sb.size() != 0));
      checkOutput("stress onehot", 8'($countones(button_ready) > 1), 8'h00);
      checkOutput("stress br subset", 8'(button_ready & ~bv), 8'h00);
      if (sb.size() == 4) checkOutput("stress full br", 8'(button_ready), 8'h00);
      if (key_valid && key_ready && sb.size() != 0) begin
        checkOutput("stress code", key_code, sb[0]);
        void'(sb.pop_front());
        received++;
      end
      cool = '0;
      for (int i = 0; i < 4; i++) begin
        if (button_ready[i] && bv[i]) begin
          sb.push_back(8'h80 + 8'(i));
          remaining[i]--;
          cool[i] = 1'b1;
        end
      end
      cycles++;
    end
    checkOutput("stress received", 8'(received), 8'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
